// File: rtl/program_loader.sv
// program_loader: boot-time stage that turns a byte stream into 32-bit
// instruction-memory writes and releases the processor once the image is in.
//
// Image: 16-bit word count N (MSB first), then N big-endian 32-bit words.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// (XOR of all header and data bytes); a mismatch aborts the load.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_in_data/valid     stream byte and its valid
//   o_in_ready          loader accepts a byte this cycle
//   o_imem_wr_en        one-cycle instruction memory write strobe
//   o_imem_wr_addr      byte address BASE_ADDR + 4*index (wraps mod 2^32)
//   o_imem_wr_data      packed instruction word
//   o_words_loaded      words written so far
//   o_cpu_run           image complete, processor may run
//   o_error             sticky load abort
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            i_in_data,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic                  o_imem_wr_en,
    output logic [31:0]           o_imem_wr_addr,
    output logic [31:0]           o_imem_wr_data,
    output logic [ADDR_WIDTH:0]   o_words_loaded,
    output logic                  o_cpu_run,
    output logic                  o_error
);

    localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
    localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHK    = 3'd3,
`endif
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FINAL = S_CHK;
`else
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_hdr_hi;
    logic [CNT_W-1:0]   r_n;
    logic [1:0]         r_byte_idx;
    logic [31:0]        r_word;
    logic [31:0]        r_wr_addr;
    logic [CNT_W-1:0]   r_words_loaded;
    logic               r_wr_en;
    logic               r_in_ready;
    logic               r_cpu_run;
    logic               r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic               w_xfer;
    logic [15:0]        w_hdr_n;
    logic               w_last_word;
    logic               w_word_done;
    logic               w_in_ready_nxt;
    logic               w_cpu_run_nxt;
    logic               w_error_nxt;

    assign w_xfer      = i_in_valid & r_in_ready;
    assign w_hdr_n     = {r_hdr_hi, i_in_data};
    assign w_last_word = (CNT_W'(r_words_loaded + CNT_W'(1)) == r_n);
    assign w_word_done = (r_state == S_DATA) && w_xfer && (r_byte_idx == 2'd3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HDR_HI;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR_HI: if (w_xfer) w_next = S_HDR_LO;
            S_HDR_LO: begin
                if (w_xfer) begin
                    if (w_hdr_n == 16'h0)
                        w_next = S_FINAL;
                    else if (32'(w_hdr_n) > MAX_WORDS)
                        w_next = S_ERR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA: if (w_word_done && w_last_word) w_next = S_FINAL;
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (w_xfer) w_next = (i_in_data == r_csum) ? S_DONE : S_ERR;
`endif
            default: w_next = r_state;
        endcase
    end

    // Output decode on the next state so the status outputs can be registered
    always_comb begin
        w_in_ready_nxt = 1'b0;
        w_cpu_run_nxt  = 1'b0;
        w_error_nxt    = 1'b0;
        case (w_next)
            S_HDR_HI, S_HDR_LO, S_DATA: w_in_ready_nxt = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:                      w_in_ready_nxt = 1'b1;
`endif
            S_DONE:                     w_cpu_run_nxt  = 1'b1;
            S_ERR:                      w_error_nxt    = 1'b1;
            default:                    w_in_ready_nxt = 1'b0;
        endcase
    end

    // Datapath and registered outputs; reset discards any partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_hi       <= 8'h0;
            r_n            <= '0;
            r_byte_idx     <= 2'd0;
            r_word         <= 32'h0;
            r_wr_addr      <= 32'h0;
            r_words_loaded <= '0;
            r_wr_en        <= 1'b0;
            r_in_ready     <= 1'b0;
            r_cpu_run      <= 1'b0;
            r_error        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum         <= 8'h0;
`endif
        end else begin
            r_in_ready <= w_in_ready_nxt;
            r_cpu_run  <= w_cpu_run_nxt;
            r_error    <= w_error_nxt;
            r_wr_en    <= w_word_done;
            if (w_xfer) begin
                case (r_state)
                    S_HDR_HI: r_hdr_hi <= i_in_data;
                    S_HDR_LO: r_n      <= CNT_W'(w_hdr_n);
                    S_DATA: begin
                        r_word     <= {r_word[23:0], i_in_data};
                        r_byte_idx <= 2'(r_byte_idx + 2'd1);
                    end
                    default: ;
                endcase
`ifdef LOADER_CHECKSUM_EN
                if (r_state == S_HDR_HI || r_state == S_HDR_LO || r_state == S_DATA)
                    r_csum <= r_csum ^ i_in_data;
`endif
            end
            if (w_word_done) begin
                r_wr_addr      <= 32'(BASE_ADDR + (32'(r_words_loaded) << 2));
                r_words_loaded <= CNT_W'(r_words_loaded + CNT_W'(1));
            end
        end
    end

    assign o_in_ready     = r_in_ready;
    assign o_imem_wr_en   = r_wr_en;
    assign o_imem_wr_addr = r_wr_addr;
    assign o_imem_wr_data = r_word;
    assign o_words_loaded = r_words_loaded;
    assign o_cpu_run      = r_cpu_run;
    assign o_error        = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (BASE_ADDR overridden to 0x100).
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_in_data = 8'h0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic        o_imem_wr_en;
    logic [31:0] o_imem_wr_addr;
    logic [31:0] o_imem_wr_data;
    logic [8:0]  o_words_loaded;
    logic        o_cpu_run;
    logic        o_error;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [7:0] csum = 8'h0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic        q_run[$];
    int          q_cyc[$];

    program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(BASE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_in_data      (i_in_data),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .o_imem_wr_en   (o_imem_wr_en),
        .o_imem_wr_addr (o_imem_wr_addr),
        .o_imem_wr_data (o_imem_wr_data),
        .o_words_loaded (o_words_loaded),
        .o_cpu_run      (o_cpu_run),
        .o_error        (o_error)
    );

    always #5 clk = ~clk;

    // Write-port monitor: values seen before each edge are the settled outputs
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_imem_wr_en) begin
            q_addr.push_back(o_imem_wr_addr);
            q_data.push_back(o_imem_wr_data);
            q_run.push_back(o_cpu_run);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        i_in_data  = b;
        i_in_valid = 1'b1;
        while (!o_in_ready && k < 20) begin
            tick();
            k++;
        end
        if (k == 20) begin
            n_cmp++;
            n_fail++;
            $error("FAIL send_timeout: observed in_ready=0 expected=1");
        end
        tick();
        i_in_valid = 1'b0;
        csum = csum ^ b;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send(t[31:24]);
            t = t << 8;
        end
    endtask

    task automatic do_reset(input string tag);
        i_in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check({tag, "_rst_ready"}, 64'(o_in_ready), 64'd0);
        check({tag, "_rst_wren"},  64'(o_imem_wr_en), 64'd0);
        check({tag, "_rst_run"},   64'(o_cpu_run), 64'd0);
        check({tag, "_rst_err"},   64'(o_error), 64'd0);
        check({tag, "_rst_words"}, 64'(o_words_loaded), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        csum = 8'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        tick();
        do_reset("init");
        check("init_ready_after_rst", 64'(o_in_ready), 64'd1);

        // Single-word image, one byte per cycle
        b = q_addr.size();
        send(8'h00); send(8'h01);
        send_word(32'h2408_0005);
        check("a_wren", 64'(o_imem_wr_en), 64'd1);
        check("a_addr", 64'(o_imem_wr_addr), 64'(BASE));
        check("a_data", 64'(o_imem_wr_data), 64'h2408_0005);
        check("a_words", 64'(o_words_loaded), 64'd1);
        check("a_run_with_write", 64'(o_cpu_run), CSUM ? 64'd0 : 64'd1);
        if (CSUM) begin
            send(csum);
            check("a_run_after_csum", 64'(o_cpu_run), 64'd1);
        end
        tick();
        check("a_wren_pulse", 64'(o_imem_wr_en), 64'd0);
        check("a_ready_done", 64'(o_in_ready), 64'd0);
        check("a_err", 64'(o_error), 64'd0);
        // Bytes offered in DONE are ignored
        i_in_data = 8'h55; i_in_valid = 1'b1;
        tick(); tick(); tick();
        i_in_valid = 1'b0;
        check("a_done_words", 64'(o_words_loaded), 64'd1);
        check("a_done_run", 64'(o_cpu_run), 64'd1);
        check("a_nwrites", 64'(q_addr.size() - b), 64'd1);

        // Three words with idle cycles between bytes
        do_reset("b");
        b = q_addr.size();
        send(8'h00); tick(); send(8'h03); tick();
        for (int w = 1; w <= 3; w++) begin
            for (int i = 0; i < 4; i++) begin
                send(8'(w * 8'h11));
                tick();
            end
        end
        if (CSUM) begin
            check("b_run_before_csum", 64'(o_cpu_run), 64'd0);
            send(csum);
        end
        tick();
        check("b_nwrites", 64'(q_addr.size() - b), 64'd3);
        if (q_addr.size() - b == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b_addr%0d", i), 64'(q_addr[b+i]), 64'(BASE + 32'(4 * i)));
                check($sformatf("b_data%0d", i), 64'(q_data[b+i]), 64'(32'h1111_1111 * (i + 1)));
                check($sformatf("b_run%0d", i), 64'(q_run[b+i]), (i == 2 && !CSUM) ? 64'd1 : 64'd0);
            end
            check("b_gap", 64'(q_cyc[b+1] - q_cyc[b]), 64'd8);
        end
        check("b_run", 64'(o_cpu_run), 64'd1);
        check("b_words", 64'(o_words_loaded), 64'd3);

        // Two words back to back: strobes four cycles apart
        do_reset("c");
        b = q_addr.size();
        send(8'h00); send(8'h02);
        send_word(32'hAABB_CCDD);
        send_word(32'h0102_0304);
        if (CSUM) send(csum);
        tick();
        check("c_nwrites", 64'(q_addr.size() - b), 64'd2);
        if (q_addr.size() - b == 2) begin
            check("c_gap", 64'(q_cyc[b+1] - q_cyc[b]), 64'd4);
            check("c_data1", 64'(q_data[b+1]), 64'h0102_0304);
            check("c_addr1", 64'(q_addr[b+1]), 64'(BASE + 32'd4));
        end

        // Empty image
        do_reset("d");
        b = q_addr.size();
        send(8'h00); send(8'h00);
        if (CSUM) begin
            check("d_run_pre_csum", 64'(o_cpu_run), 64'd0);
            check("d_ready_chk", 64'(o_in_ready), 64'd1);
            send(8'h00);
        end
        check("d_run", 64'(o_cpu_run), 64'd1);
        check("d_ready", 64'(o_in_ready), 64'd0);
        check("d_words", 64'(o_words_loaded), 64'd0);
        tick();
        check("d_nwrites", 64'(q_addr.size() - b), 64'd0);

        // N = MAX_WORDS is accepted
        do_reset("e");
        send(8'h01); send(8'h00);
        check("e_max_err", 64'(o_error), 64'd0);
        check("e_max_ready", 64'(o_in_ready), 64'd1);

        // N = MAX_WORDS + 1 aborts
        do_reset("f");
        b = q_addr.size();
        send(8'h01); send(8'h01);
        check("f_err", 64'(o_error), 64'd1);
        check("f_ready", 64'(o_in_ready), 64'd0);
        check("f_run", 64'(o_cpu_run), 64'd0);
        i_in_data = 8'h12; i_in_valid = 1'b1;
        tick(); tick();
        i_in_valid = 1'b0;
        check("f_err_sticky", 64'(o_error), 64'd1);
        check("f_nwrites", 64'(q_addr.size() - b), 64'd0);

        // Reset mid-word, then a clean reload
        do_reset("g");
        send(8'h00); send(8'h01); send(8'h24); send(8'h08);
        do_reset("g_mid");
        b = q_addr.size();
        send(8'h00); send(8'h01);
        send_word(32'h2408_0005);
        check("g_addr", 64'(o_imem_wr_addr), 64'(BASE));
        check("g_data", 64'(o_imem_wr_data), 64'h2408_0005);
        check("g_words", 64'(o_words_loaded), 64'd1);

`ifdef LOADER_CHECKSUM_EN
        // Corrupted checksum byte
        do_reset("h");
        send(8'h00); send(8'h01);
        send_word(32'h2408_0005);
        send(csum ^ 8'h01);
        check("h_err", 64'(o_error), 64'd1);
        check("h_run", 64'(o_cpu_run), 64'd0);
        check("h_words", 64'(o_words_loaded), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
